// File: rtl/prefetch_unit_if.sv
// -----------------------------------------------------------------------------
// prefetch_unit_if
// Purpose : bundles the fetch-side bus, the redirect input and the decoder-side
//           handshake of the instruction prefetch unit.
// Modports:
//   master - the prefetch unit itself (drives requests and the queue head)
//   slave  - the environment (instruction bus, decoder, redirect source)
// Signals :
//   jump_i, jump_addr_i                  redirect request and target
//   ireqvalid_o, ireqready_i, ireqaddr_o fetch request channel
//   irspvalid_i, irsprerr_i, irspdata_i  fetch response channel
//   ins_valid_o, ins_accept_i            decoder handshake
//   ins_o, ins_pc_o, ins_rerr_o          queue head toward the decoder
// -----------------------------------------------------------------------------
interface prefetch_unit_if #(
  parameter int C_XLEN = 32
);
  logic              jump_i;
  logic [C_XLEN-1:0] jump_addr_i;
  logic              ireqvalid_o;
  logic              ireqready_i;
  logic [C_XLEN-1:0] ireqaddr_o;
  logic              irspvalid_i;
  logic              irsprerr_i;
  logic [31:0]       irspdata_i;
  logic              ins_valid_o;
  logic              ins_accept_i;
  logic [31:0]       ins_o;
  logic [C_XLEN-1:0] ins_pc_o;
  logic              ins_rerr_o;

  modport master (
    input  jump_i, jump_addr_i, ireqready_i, irspvalid_i, irsprerr_i,
           irspdata_i, ins_accept_i,
    output ireqvalid_o, ireqaddr_o, ins_valid_o, ins_o, ins_pc_o, ins_rerr_o
  );

  modport slave (
    output jump_i, jump_addr_i, ireqready_i, irspvalid_i, irsprerr_i,
           irspdata_i, ins_accept_i,
    input  ireqvalid_o, ireqaddr_o, ins_valid_o, ins_o, ins_pc_o, ins_rerr_o
  );
endinterface

// File: rtl/prefetch_unit.sv
// -----------------------------------------------------------------------------
// prefetch_unit
// Purpose : instruction fetch front end. Issues in-order 32-bit word fetches,
//           queues the responses together with their PCs and hands them to the
//           decoder over a valid/accept handshake. A jump flushes the queue,
//           restarts fetching at the new PC and discards every response that
//           is still in flight for the old stream.
// Ports   :
//   clk_i    in  clock, all logic on the rising edge
//   reset_i  in  synchronous active-high reset
//   bus      master modport of prefetch_unit_if (request/response bus,
//            redirect input, decoder handshake)
// Parameters:
//   C_XLEN         address/PC width
//   C_FIFO_DEPTH_X log2 of queue depth (must be >= 1)
//   C_RESET_VECTOR first fetch PC after reset
// Configuration:
//   PFU_RERR_HALT_EN  when defined, a queued bus-error entry stops further
//                     requests until the next jump or reset; when undefined,
//                     fetching continues and the error only marks that entry.
// -----------------------------------------------------------------------------
module prefetch_unit #(
  parameter int                C_XLEN         = 32,
  parameter int                C_FIFO_DEPTH_X = 2,
  parameter logic [C_XLEN-1:0] C_RESET_VECTOR = {C_XLEN{1'b0}}
) (
  input logic             clk_i,
  input logic             reset_i,
  prefetch_unit_if.master bus
);

  localparam int PW    = C_FIFO_DEPTH_X;      // pointer width
  localparam int CW    = C_FIFO_DEPTH_X + 1;  // occupancy / credit counter width
  localparam int DEPTH = 2 ** C_FIFO_DEPTH_X;
  localparam logic [CW:0] C_DEPTH = (CW+1)'(DEPTH);

  // Queue storage
  logic [31:0]       data_q [DEPTH];
  logic [C_XLEN-1:0] pc_q   [DEPTH];
  logic              rerr_q [DEPTH];

  // Registered state
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;
  logic [C_XLEN-1:0] req_addr;
  logic [C_XLEN-1:0] rsp_pc;
  logic              req_valid;
  logic              halt;

  // Next-state values
  logic [PW-1:0]     wr_ptr_nxt;
  logic [PW-1:0]     rd_ptr_nxt;
  logic [CW-1:0]     count_nxt;
  logic [CW-1:0]     outstanding_nxt;
  logic [CW-1:0]     discard_nxt;
  logic [C_XLEN-1:0] req_addr_nxt;
  logic [C_XLEN-1:0] rsp_pc_nxt;
  logic              req_valid_nxt;
  logic              halt_nxt;

  // Per-cycle events
  logic              head_valid;
  logic              req_fire;
  logic              rsp_drop;
  logic              push;
  logic              pop;
  logic [C_XLEN-1:0] jump_target;

  // Handshake events of the current cycle; a jump overrides both queue ports.
  always_comb begin
    jump_target = bus.jump_addr_i & {{(C_XLEN-2){1'b1}}, 2'b00};
    head_valid  = (count != {CW{1'b0}});
    req_fire    = req_valid & bus.ireqready_i;
    rsp_drop    = (discard != {CW{1'b0}});
    push        = bus.irspvalid_i & ~rsp_drop & ~bus.jump_i;
    pop         = head_valid & bus.ins_accept_i & ~bus.jump_i;
  end

  // Next-state computation for pointers, counters, fetch PCs and halt.
  always_comb begin
    wr_ptr_nxt      = wr_ptr;
    rd_ptr_nxt      = rd_ptr;
    count_nxt       = count;
    outstanding_nxt = outstanding;
    discard_nxt     = discard;
    req_addr_nxt    = req_addr;
    rsp_pc_nxt      = rsp_pc;
    halt_nxt        = halt;

    // Outstanding counts requests on the bus, stale or not.
    case ({req_fire, bus.irspvalid_i})
      2'b10:   outstanding_nxt = outstanding + CW'(1'b1);
      2'b01:   outstanding_nxt = outstanding - CW'(1'b1);
      default: outstanding_nxt = outstanding;
    endcase

    if (bus.jump_i) begin
      // Everything already requested, including a request accepted in this
      // cycle, belongs to the old stream and must be thrown away on return.
      wr_ptr_nxt   = {PW{1'b0}};
      rd_ptr_nxt   = {PW{1'b0}};
      count_nxt    = {CW{1'b0}};
      discard_nxt  = outstanding_nxt;
      req_addr_nxt = jump_target;
      rsp_pc_nxt   = jump_target;
      halt_nxt     = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_nxt = wr_ptr + PW'(1'b1);
        rsp_pc_nxt = rsp_pc + C_XLEN'(3'd4);
      end else begin
        wr_ptr_nxt = wr_ptr;
        rsp_pc_nxt = rsp_pc;
      end

      if (pop) begin
        rd_ptr_nxt = rd_ptr + PW'(1'b1);
      end else begin
        rd_ptr_nxt = rd_ptr;
      end

      case ({push, pop})
        2'b10:   count_nxt = count + CW'(1'b1);
        2'b01:   count_nxt = count - CW'(1'b1);
        default: count_nxt = count;
      endcase

      if (bus.irspvalid_i && rsp_drop) begin
        discard_nxt = discard - CW'(1'b1);
      end else begin
        discard_nxt = discard;
      end

      if (req_fire) begin
        req_addr_nxt = req_addr + C_XLEN'(3'd4);
      end else begin
        req_addr_nxt = req_addr;
      end

`ifdef PFU_RERR_HALT_EN
      if (push && bus.irsprerr_i) begin
        halt_nxt = 1'b1;
      end else begin
        halt_nxt = halt;
      end
`else
      halt_nxt = 1'b0;
`endif
    end

    // Credit: queued words plus words still on the bus never exceed the
    // queue depth, so a response always finds a free slot.
    req_valid_nxt = (({1'b0, count_nxt} + {1'b0, outstanding_nxt}) < C_DEPTH)
                    && !halt_nxt;
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr      <= {PW{1'b0}};
      rd_ptr      <= {PW{1'b0}};
      count       <= {CW{1'b0}};
      outstanding <= {CW{1'b0}};
      discard     <= {CW{1'b0}};
      req_addr    <= C_RESET_VECTOR;
      rsp_pc      <= C_RESET_VECTOR;
      req_valid   <= 1'b0;
      halt        <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      req_addr    <= req_addr_nxt;
      rsp_pc      <= rsp_pc_nxt;
      req_valid   <= req_valid_nxt;
      halt        <= halt_nxt;
    end
  end

  // Queue storage; cleared on reset so the head outputs start at zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= 32'h0000_0000;
        pc_q[i]   <= {C_XLEN{1'b0}};
        rerr_q[i] <= 1'b0;
      end
    end else if (push) begin
      data_q[wr_ptr] <= bus.irspdata_i;
      pc_q[wr_ptr]   <= rsp_pc;
      rerr_q[wr_ptr] <= bus.irsprerr_i;
    end else begin
      data_q[wr_ptr] <= data_q[wr_ptr];
    end
  end

  // Outputs come straight from registers; no response-to-decoder bypass.
  assign bus.ireqvalid_o = req_valid;
  assign bus.ireqaddr_o  = req_addr;
  assign bus.ins_valid_o = head_valid;
  assign bus.ins_o       = data_q[rd_ptr];
  assign bus.ins_pc_o    = pc_q[rd_ptr];
  assign bus.ins_rerr_o  = rerr_q[rd_ptr];

endmodule

// File: tb/tb_prefetch_unit.sv
// -----------------------------------------------------------------------------
// tb_prefetch_unit
// Directed bench for prefetch_unit with a 1-cycle memory model and a
// scoreboard of expected queue entries. Each cycle the bench checks the
// decoder head, the request valid (credit rule) and the request address
// against its own model, then drives inputs and predicts the edge's effects.
// -----------------------------------------------------------------------------
module tb_prefetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        rerr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        stale;
  } req_t;

  logic clk;
  logic reset;

  prefetch_unit_if #(.C_XLEN(32)) ifc ();

  prefetch_unit #(
    .C_XLEN(32),
    .C_FIFO_DEPTH_X(2),
    .C_RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  req_t        rq[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_req    = 0;
  int          n_drop   = 0;
  logic        ready_cfg = 1'b0;
  logic        mem_hold  = 1'b0;
  logic        err_en    = 1'b0;
  logic [31:0] err_addr  = 32'h0;
  logic        halt_m    = 1'b0;
  logic [31:0] exp_addr  = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic jmp, input logic [31:0] jaddr, input logic acc);
    logic rsp;
    logic req_ok;
    req_t r;
    exp_t e;
    r = '{addr: 32'h0, stale: 1'b0};
    // Observe state left by the previous edge.
    chk("ins_valid", ifc.ins_valid_o, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("ins_pc", ifc.ins_pc_o, sb[0].pc);
      chk("ins_data", ifc.ins_o, sb[0].data);
      chk("ins_rerr", ifc.ins_rerr_o, sb[0].rerr);
    end
    req_ok = ((sb.size() + rq.size()) < 4) && !halt_m;
    chk("ireqvalid", ifc.ireqvalid_o, req_ok);
    chk("ireqaddr", ifc.ireqaddr_o, exp_addr);
    // Drive inputs for the coming edge.
    ifc.jump_i       = jmp;
    ifc.jump_addr_i  = jaddr;
    ifc.ins_accept_i = acc;
    ifc.ireqready_i  = ready_cfg;
    rsp = !mem_hold && (rq.size() != 0);
    if (rsp) begin
      r = rq.pop_front();
      ifc.irspvalid_i = 1'b1;
      ifc.irspdata_i  = mem_word(r.addr);
      ifc.irsprerr_i  = err_en && (r.addr == err_addr);
    end else begin
      ifc.irspvalid_i = 1'b0;
      ifc.irspdata_i  = 32'h0;
      ifc.irsprerr_i  = 1'b0;
    end
    // Predict the edge.
    if (req_ok && ready_cfg) begin
      rq.push_back('{addr: exp_addr, stale: 1'b0});
      exp_addr = exp_addr + 32'd4;
      n_req++;
    end
    if (acc && !jmp && sb.size() != 0) void'(sb.pop_front());
    if (rsp) begin
      if (r.stale || jmp) begin
        n_drop++;
      end else begin
        e.pc   = r.addr;
        e.data = mem_word(r.addr);
        e.rerr = ifc.irsprerr_i;
        sb.push_back(e);
`ifdef PFU_RERR_HALT_EN
        if (e.rerr) halt_m = 1'b1;
`endif
      end
    end
    if (jmp) begin
      foreach (rq[i]) rq[i].stale = 1'b1;
      sb.delete();
      exp_addr = jaddr & 32'hFFFF_FFFC;
      halt_m   = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    ifc.jump_i       = 1'b0;
    ifc.jump_addr_i  = 32'h0;
    ifc.ireqready_i  = 1'b0;
    ifc.irspvalid_i  = 1'b0;
    ifc.irsprerr_i   = 1'b0;
    ifc.irspdata_i   = 32'h0;
    ifc.ins_accept_i = 1'b0;
    sb.delete();
    rq.delete();
    halt_m   = 1'b0;
    mem_hold = 1'b0;
    exp_addr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ireqvalid", ifc.ireqvalid_o, 32'h0);
    chk("rst_ireqaddr", ifc.ireqaddr_o, 32'h0);
    chk("rst_ins_valid", ifc.ins_valid_o, 32'h0);
    chk("rst_ins", ifc.ins_o, 32'h0);
    chk("rst_ins_pc", ifc.ins_pc_o, 32'h0);
    chk("rst_ins_rerr", ifc.ins_rerr_o, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // T1: streaming after reset
    do_reset();
    ready_cfg = 1'b1;
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t1_pc0", ifc.ins_pc_o, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t1_pc4", ifc.ins_pc_o, 32'h4);
    chk("t1_valid", ifc.ins_valid_o, 32'h1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t1_pc8", ifc.ins_pc_o, 32'h8);
    repeat (6) cycle(1'b0, 32'h0, 1'b1);

    // T2: fill with no accepts, then one accept frees one credit
    do_reset();
    n_req = 0;
    repeat (10) cycle(1'b0, 32'h0, 1'b0);
    chk("t2_reqs", n_req, 32'd4);
    chk("t2_stall", ifc.ireqvalid_o, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    repeat (4) cycle(1'b0, 32'h0, 1'b0);
    chk("t2_reqs_after", n_req, 32'd5);
    chk("t2_addr", ifc.ireqaddr_o, 32'h14);
    repeat (8) cycle(1'b0, 32'h0, 1'b1);

    // T3: redirect with two requests in flight
    do_reset();
    mem_hold = 1'b1;
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    ready_cfg = 1'b0;
    cycle(1'b1, 32'h203, 1'b1);
    chk("t3_addr", ifc.ireqaddr_o, 32'h200);
    mem_hold  = 1'b0;
    ready_cfg = 1'b1;
    n_drop    = 0;
    for (int i = 0; i < 20 && !ifc.ins_valid_o; i++) cycle(1'b0, 32'h0, 1'b0);
    chk("t3_valid", ifc.ins_valid_o, 32'h1);
    chk("t3_pc", ifc.ins_pc_o, 32'h200);
    chk("t3_drops", n_drop, 32'd2);
    repeat (6) cycle(1'b0, 32'h0, 1'b1);

    // T4: bus error on the fetch of 0x8
    do_reset();
    err_en   = 1'b1;
    err_addr = 32'h8;
    for (int i = 0; i < 20 && !(ifc.ins_valid_o && ifc.ins_pc_o == 32'h8); i++)
      cycle(1'b0, 32'h0, 1'b1);
    chk("t4_pc", ifc.ins_pc_o, 32'h8);
    chk("t4_rerr", ifc.ins_rerr_o, 32'h1);
    repeat (8) cycle(1'b0, 32'h0, 1'b1);
`ifdef PFU_RERR_HALT_EN
    chk("t4_halt_valid", ifc.ireqvalid_o, 32'h0);
    chk("t4_halt_addr", ifc.ireqaddr_o, 32'h10);
    cycle(1'b1, 32'h40, 1'b1);
    repeat (6) cycle(1'b0, 32'h0, 1'b1);
    chk("t4_resume", ifc.ireqaddr_o > 32'h40, 32'h1);
`else
    chk("t4_continue", ifc.ireqvalid_o, 32'h1);
    chk("t4_past_err", ifc.ireqaddr_o > 32'h10, 32'h1);
`endif
    err_en = 1'b0;

    // T5: full queue, same-cycle push and pop
    do_reset();
    repeat (8) cycle(1'b0, 32'h0, 1'b0);
    chk("t5_full", ifc.ireqvalid_o, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t5_head", ifc.ins_pc_o, 32'h8);
    repeat (8) cycle(1'b0, 32'h0, 1'b1);

    // T6: address wrap
    do_reset();
    ready_cfg = 1'b0;
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
    ready_cfg = 1'b1;
    chk("t6_addr_top", ifc.ireqaddr_o, 32'hFFFF_FFFC);
    cycle(1'b0, 32'h0, 1'b0);
    chk("t6_addr_wrap", ifc.ireqaddr_o, 32'h0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("t6_pc_top", ifc.ins_pc_o, 32'hFFFF_FFFC);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t6_pc_wrap", ifc.ins_pc_o, 32'h0);
    chk("t6_valid", ifc.ins_valid_o, 32'h1);
    repeat (6) cycle(1'b0, 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
